// File: rtl/spi_wb_target.sv
// SPI target (mode 0, MSB first) that issues 32-bit Wishbone cycles.
// Optional burst auto-increment: define SPI_WB_AUTOINC_EN.
module spi_wb_target #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        sclk_pad_i,
    input  logic        ss_pad_i,
    input  logic        mosi_pad_i,
    output logic        miso_pad_o,
    output logic        miso_oe_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WB, S_RDATA, S_STAT, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_sclk_s, r_ss_s, r_mosi_s;
    logic        r_sclk_d, r_ss_d;
    logic [30:0] r_sh;
    logic [31:0] r_adr, r_dat, r_miso;
    logic [3:0]  r_sel;
    logic        r_we, r_cyc, r_rose;
    logic [5:0]  r_cnt;
    logic [15:0] r_tmo;
    logic [7:0]  r_stat;

    logic        w_sclk, w_mosi, w_ss_lo, w_ss_fall, w_rise, w_fall;
    logic        w_last, w_done;
    logic [5:0]  w_len;
    logic [31:0] w_sh_next, w_rdt;
    logic [7:0]  w_status;

    assign w_sclk    = r_sclk_s[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_s[SYNC_STAGES-1];
    assign w_ss_lo   = ~r_ss_s[SYNC_STAGES-1];
    assign w_ss_fall = w_ss_lo & r_ss_d;
    assign w_rise    = w_sclk & ~r_sclk_d & w_ss_lo;
    // a falling edge only counts once its rising edge was seen in this phase
    assign w_fall    = ~w_sclk & r_sclk_d & w_ss_lo & r_rose;
    assign w_sh_next = {r_sh, w_mosi};
    assign w_last    = (r_cnt == w_len);
    assign w_done    = wb_ack_i | wb_err_i | (r_tmo == 16'(TIMEOUT - 1));
    assign w_status  = wb_err_i ? 8'hE1 : (wb_ack_i ? 8'hA5 : 8'hE2);
    assign w_rdt     = (wb_ack_i & ~wb_err_i) ? wb_dat_i : 32'h0;

    assign miso_pad_o = r_miso[31];
    assign miso_oe_o  = w_ss_lo;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_cyc;
    assign wb_adr_o   = r_cyc ? r_adr : 32'h0;
    assign wb_dat_o   = r_cyc ? r_dat : 32'h0;
    assign wb_sel_o   = r_cyc ? r_sel : 4'h0;
    assign wb_we_o    = r_cyc & r_we;
    assign busy_o     = (r_state != S_IDLE) | r_cyc;

    // Field length of the current state
    always_comb begin
        w_len = 6'd31;
        if (r_state == S_CMD || r_state == S_STAT) w_len = 6'd7;
    end

    // Pad synchronizers and one-cycle edge history
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sclk_s <= '0;
            r_ss_s   <= '1;
            r_mosi_s <= '0;
            r_sclk_d <= 1'b0;
            r_ss_d   <= 1'b1;
        end else begin
            r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk_pad_i};
            r_ss_s   <= {r_ss_s[SYNC_STAGES-2:0], ss_pad_i};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi_pad_i};
            r_sclk_d <= w_sclk;
            r_ss_d   <= r_ss_s[SYNC_STAGES-1];
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; a live bus cycle is always finished first
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_ss_fall) w_next = S_CMD;
            S_CMD:   if (!w_ss_lo) w_next = S_IDLE;
                     else if (w_rise && w_last) w_next = S_ADDR;
            S_ADDR:  if (!w_ss_lo) w_next = S_IDLE;
                     else if (w_rise && w_last)
                         w_next = r_we ? S_WDATA : S_WB;
            S_WDATA: if (!w_ss_lo) w_next = S_IDLE;
                     else if (w_rise && w_last) w_next = S_WB;
            S_WB:    if (w_done)
                         w_next = !w_ss_lo ? S_IDLE :
                                  (r_we ? S_STAT : S_RDATA);
            S_RDATA: if (!w_ss_lo) w_next = S_IDLE;
                     else if (w_fall && w_last) w_next = S_STAT;
            S_STAT:  if (!w_ss_lo) w_next = S_IDLE;
`ifdef SPI_WB_AUTOINC_EN
                     else if (w_fall && w_last)
                         w_next = r_we ? S_WDATA : S_WB;
`else
                     else if (w_fall && w_last) w_next = S_DONE;
`endif
            S_DONE:  if (!w_ss_lo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shift registers, bit/timeout counters and bus cycle control
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sh   <= '0;
            r_adr  <= '0;
            r_dat  <= '0;
            r_miso <= '0;
            r_sel  <= '0;
            r_we   <= 1'b0;
            r_cyc  <= 1'b0;
            r_rose <= 1'b0;
            r_cnt  <= '0;
            r_tmo  <= '0;
            r_stat <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_rose <= 1'b0;
                    r_miso <= '0;
                end
                S_CMD, S_ADDR, S_WDATA: if (w_rise) begin
                    r_sh  <= w_sh_next[30:0];
                    r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
                    if (w_last) begin
                        if (r_state == S_CMD) begin
                            r_we  <= w_sh_next[7];
                            r_sel <= w_sh_next[3:0];
                        end else if (r_state == S_ADDR) begin
                            r_adr <= w_sh_next;
                            if (!r_we) begin
                                r_cyc <= 1'b1;
                                r_tmo <= '0;
                            end
                        end else begin
                            r_dat <= w_sh_next;
                            r_cyc <= 1'b1;
                            r_tmo <= '0;
                        end
                    end
                end
                S_WB: begin
                    if (w_done) begin
                        r_cyc  <= 1'b0;
                        r_cnt  <= '0;
                        r_rose <= 1'b0;
                        r_stat <= w_status;
                        if (w_ss_lo)
                            r_miso <= r_we ? {w_status, 24'h0} : w_rdt;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_RDATA, S_STAT: begin
                    if (w_rise) begin
                        r_rose <= 1'b1;
                    end else if (w_fall) begin
                        r_rose <= 1'b0;
                        r_cnt  <= w_last ? 6'd0 : r_cnt + 6'd1;
                        if (!w_last) begin
                            r_miso <= {r_miso[30:0], 1'b0};
                        end else if (r_state == S_RDATA) begin
                            r_miso <= {r_stat, 24'h0};
                        end else begin
                            r_miso <= '0;
`ifdef SPI_WB_AUTOINC_EN
                            r_adr <= r_adr + 32'd4;
                            if (!r_we) begin
                                r_cyc <= 1'b1;
                                r_tmo <= '0;
                            end
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_wb_target.sv
// Randomized scoreboard bench for spi_wb_target.
// Host SPI driver and Wishbone slave model feed a single checking monitor.
module tb_spi_wb_target;

    localparam int SYNC = 2;
    localparam int TMO  = 16;
    localparam int HALF = 6;
    localparam int PAUSE = 40;

    logic        clk, rst, sclk, ss, mosi;
    logic        miso_pad_o, miso_oe_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, busy_o;

    spi_wb_target #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .sclk_pad_i(sclk), .ss_pad_i(ss), .mosi_pad_i(mosi),
        .miso_pad_o(miso_pad_o), .miso_oe_o(miso_oe_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy_o(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    typedef struct { string nm; logic [31:0] v; } chk_t;
    typedef struct {
        logic [31:0] adr; logic [3:0] sel; logic we;
        logic [31:0] dat; int len;
    } wb_exp_t;

    chk_t    exp_q[$], got_q[$];
    wb_exp_t wb_q[$];
    int      n_cmp = 0, n_bad = 0;
    logic    end_req = 1'b0, end_done = 1'b0;

    // slave behaviour: 0 ack, 1 err, 2 silent, 3 ack+err
    int          sl_mode = 0, sl_delay = 1, sl_cnt = 0;
    logic [31:0] sl_rdata = '0;

    function automatic logic [31:0] model_status(input int mode);
        if (mode == 1 || mode == 3) return 32'hE1;
        if (mode == 0) return 32'hA5;
        return 32'hE2;
    endfunction

    function automatic logic [31:0] model_rdata(input int mode,
                                                input logic [31:0] rd);
        return (mode == 0) ? rd : 32'h0;
    endfunction

    function automatic logic [31:0] outs_vec();
        return 32'({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, miso_oe_o,
                    miso_pad_o, |wb_adr_o, |wb_dat_o, |wb_sel_o});
    endfunction

    task automatic push_exp(input string n, input logic [31:0] v);
        chk_t c;
        c.nm = n; c.v = v;
        exp_q.push_back(c);
    endtask

    task automatic push_got(input string n, input logic [31:0] v);
        chk_t c;
        c.nm = n; c.v = v;
        got_q.push_back(c);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wishbone slave: responds sl_delay cycles into the bus cycle
    always @(negedge clk) begin
        if (rst || !wb_cyc_o) begin
            sl_cnt   = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end else begin
            sl_cnt++;
            wb_ack_i = (sl_cnt == sl_delay) && (sl_mode == 0 || sl_mode == 3);
            wb_err_i = (sl_cnt == sl_delay) && (sl_mode == 1 || sl_mode == 3);
        end
        wb_dat_i = sl_rdata;
    end

    // Monitor: bus cycles against wb_q, observed values against exp_q
    wb_exp_t cur;
    logic    m_cyc_d = 1'b0, m_on = 1'b0;
    int      m_len = 0;
    always @(negedge clk) begin
        chk_t g, e;
        if (wb_cyc_o && !m_cyc_d) begin
            chk("wb_cycle_expected", 32'(wb_q.size() != 0), 32'd1);
            if (wb_q.size() != 0) begin
                cur  = wb_q.pop_front();
                m_on = 1'b1;
                chk("wb_adr", wb_adr_o, cur.adr);
                chk("wb_sel", 32'(wb_sel_o), 32'(cur.sel));
                chk("wb_we", 32'(wb_we_o), 32'(cur.we));
                chk("wb_stb", 32'(wb_stb_o), 32'd1);
                if (cur.we) chk("wb_dat", wb_dat_o, cur.dat);
            end
            m_len = 1;
        end else if (wb_cyc_o) begin
            m_len++;
        end
        if (!wb_cyc_o && m_cyc_d && m_on) begin
            if (cur.len >= 0) chk("wb_cyc_len", 32'(m_len), 32'(cur.len));
            m_on = 1'b0;
        end
        m_cyc_d = wb_cyc_o;
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk(e.nm, g.v, e.v);
        end
        if (end_req && !end_done) begin
            chk("exp_left", 32'(exp_q.size()), 32'd0);
            chk("wb_left", 32'(wb_q.size()), 32'd0);
            end_done = 1'b1;
        end
    end

    task automatic spi_bits(input logic [31:0] tx, input int n,
                            output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[30:0], miso_pad_o};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [31:0] adr,
                         input logic [31:0] wd, input int mode,
                         input int delay, input logic [31:0] rd,
                         input logic extra);
        logic [31:0] rx;
        wb_exp_t e;
        sl_mode = mode; sl_delay = delay; sl_rdata = rd;
        e.adr = adr; e.sel = cmd[3:0]; e.we = cmd[7]; e.dat = wd;
        e.len = (mode == 2) ? TMO : delay;
        wb_q.push_back(e);
        if (!cmd[7]) push_exp("rdata", model_rdata(mode, rd));
        push_exp("status", model_status(mode));
        if (extra) begin
            push_exp("done_extra", 32'h0);
            push_exp("busy_done", 32'd1);
        end
        push_exp("idle_after", 32'd0);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(32'(cmd), 8, rx);
        spi_bits(adr, 32, rx);
        if (cmd[7]) spi_bits(wd, 32, rx);
        repeat (PAUSE) @(negedge clk);
        if (!cmd[7]) begin
            spi_bits(32'h0, 32, rx);
            push_got("rdata", rx);
        end
        spi_bits(32'h0, 8, rx);
        push_got("status", rx);
        if (extra) begin
            spi_bits(32'h5A, 8, rx);
            push_got("done_extra", rx);
            repeat (4) @(negedge clk);
            push_got("busy_done", 32'(busy_o));
        end
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        push_got("idle_after", 32'(busy_o));
    endtask

    initial begin
        logic [31:0] rx, a;
        logic [31:0] w [3];
        wb_exp_t e;
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        push_exp("reset_outs", 32'h0);
        push_got("reset_outs", outs_vec());
        repeat (4) @(negedge clk);

        frame(8'h8F, 32'h100, 32'hDEADBEEF, 0, 3, 32'h0, 1'b0);
        frame(8'h03, 32'h40, 32'h0, 0, 2, 32'h12345678, 1'b0);
        frame(8'h01, 32'h80, 32'h0, 1, 4, 32'hCAFEF00D, 1'b0);
        frame(8'h0F, 32'hC0, 32'h0, 2, 1, 32'h55AA55AA, 1'b0);
        frame(8'h02, 32'h44, 32'h0, 3, 1, 32'h77777777, 1'b0);
        frame(8'h81, 32'h48, 32'h11112222, 1, 1, 32'h0, 1'b0);

        for (int k = 0; k < 24; k++)
            frame(8'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                  $urandom_range(1, 8), $urandom, 1'b0);

`ifndef SPI_WB_AUTOINC_EN
        frame(8'h84, 32'h200, 32'h0BADF00D, 0, 2, 32'h0, 1'b1);
`endif

        // select dropped in the middle of the address field
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(32'h03, 8, rx);
        spi_bits($urandom, 20, rx);
        ss = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        push_exp("abort_addr_busy", 32'd0);
        push_got("abort_addr_busy", 32'(busy_o));
        repeat (20) @(negedge clk);

        // select dropped while the bus cycle is outstanding
        sl_mode = 0; sl_delay = 10; sl_rdata = 32'h13579BDF;
        a = $urandom;
        e.adr = a; e.sel = 4'hA; e.we = 1'b0; e.dat = '0; e.len = 10;
        wb_q.push_back(e);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(32'h0A, 8, rx);
        spi_bits(a, 32, rx);
        ss = 1'b1;
        for (int i = 0; i < 200 && busy_o; i++) @(negedge clk);
        push_exp("abort_wb_idle", 32'd0);
        push_got("abort_wb_idle", 32'(busy_o));
        repeat (20) @(negedge clk);

        // reset pulse during a silent bus cycle
        sl_mode = 2; sl_delay = 1;
        e.adr = 32'h300; e.sel = 4'h1; e.we = 1'b0; e.len = -1;
        wb_q.push_back(e);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h300, 32, rx);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_exp("midcycle_reset_outs", 32'h0);
        push_got("midcycle_reset_outs", outs_vec());
        ss = 1'b1;
        repeat (20) @(negedge clk);

`ifdef SPI_WB_AUTOINC_EN
        // write burst wrapping past the top of the address space
        sl_mode = 0; sl_delay = 2;
        a = 32'hFFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            w[k] = $urandom;
            e.adr = a; e.sel = 4'hF; e.we = 1'b1; e.dat = w[k]; e.len = 2;
            wb_q.push_back(e);
            push_exp("burst_status", 32'hA5);
            a = a + 32'd4;
        end
        ss = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(32'h8F, 8, rx);
        spi_bits(32'hFFFF_FFFC, 32, rx);
        for (int k = 0; k < 3; k++) begin
            spi_bits(w[k], 32, rx);
            repeat (PAUSE) @(negedge clk);
            spi_bits(32'h0, 8, rx);
            push_got("burst_status", rx);
        end
        ss = 1'b1;
        repeat (20) @(negedge clk);
`endif

        for (int i = 0; i < 2000 && (exp_q.size() != 0 || wb_q.size() != 0); i++)
            @(negedge clk);
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
